im_arbiter: RTL and testbench
=============================

# im_arbiter

Shares the single combinational read port of the instruction memory (4096 × 32-bit words) between two requesters: the fetch stage (master 0) and a debug/trace reader (master 1). Each cycle it grants at most one request, drives the memory word index, and captures the read word into a per-master response slot. The slot holds the word until that master accepts it. The arbiter sits between the fetch/debug logic and the memory instance, inside the CPU top level.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_3000, byte address that maps to memory word 0
- ADDR_W, 12, memory word-index width; depth is 2^ADDR_W words
- STARVE_LIMIT, 4, consecutive denied cycles after which master 1 is forced to win (fixed-priority mode only)

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- m0_req / m1_req  in  1  read request
- m0_addr / m1_addr  in  32  byte address
- m0_gnt / m1_gnt  out  1  request accepted this cycle (combinational)
- m0_rvalid / m1_rvalid  out  1  response slot full
- m0_rdata / m1_rdata  out  32  read word
- m0_rerr / m1_rerr  out  1  misaligned or out-of-range request
- m0_rready / m1_rready  in  1  master consumes the response
- im_addr  out  ADDR_W  word index to the memory
- im_rdata  in  32  memory read data

## Operation
- A master is eligible when `mX_req && (!mX_rvalid || mX_rready)`.
- At most one grant per cycle. An ineligible master never receives a grant.
- Offset = mX_addr − BASE_ADDR, computed modulo 2^32.
- im_addr = offset[ADDR_W+1:2] of the granted master. When no master is granted, im_addr holds its last driven value.
- Error check on the granted request:
  - addr[1:0] != 0 → rerr = 1
  - offset ≥ 4·2^ADDR_W → rerr = 1; this includes addresses below BASE_ADDR, which wrap to a large offset.
  - On error, rdata = 0.
- Fixed-priority mode (default):
  - Master 0 wins whenever it is eligible.
  - A starvation counter increments each cycle that master 1 is eligible but not granted, saturating at STARVE_LIMIT.
  - When the counter equals STARVE_LIMIT, master 1 wins over master 0.
  - The counter clears whenever master 1 is granted or master 1 is not requesting.
- Response slot, per master, with two states:
  - EMPTY → FULL on grant.
  - FULL → EMPTY on rready with no new grant.
  - FULL → FULL (reload) on rready together with a new grant.
  - rready asserted while EMPTY is ignored.

## Timing
- Grant is combinational in cycle N. im_rdata is sampled at the end of cycle N.
- The slot is FULL with valid rdata/rerr from cycle N+1.
- Back-to-back operation: one request per master per cycle, provided the master asserts rready every cycle. This gives full throughput of one word per cycle.
- Slot contents stay stable while FULL and rready is low.
- Both masters eligible in the same cycle: arbitration rule decides and the loser sees gnt = 0. The loser's request is not queued; the master keeps req asserted.
- Reset values: all gnt = 0, rvalid = 0, rdata = 0, rerr = 0, im_addr = 0, starvation counter = 0, round-robin pointer = master 0.
- Asserting reset_n low mid-operation clears both slots immediately. Pending responses are discarded.

## Configuration
- IM_ARB_RR_EN defined:
  - Round-robin arbitration. A 1-bit last-grant pointer gives priority to the master not granted most recently.
  - The pointer updates only on a grant.
  - The starvation counter and STARVE_LIMIT are unused and not synthesised.
- IM_ARB_RR_EN undefined: fixed priority with the starvation override described in Operation.

## Structure
- Shared package im_arb_pkg holds:
  - master index constants M_FETCH = 0 and M_DEBUG = 1
  - slot state encodings SLOT_EMPTY and SLOT_FULL
  - the default BASE_ADDR value
- Sub-module im_arb_resp_slot, instantiated twice (one per master). It holds the slot state, rdata and rerr, and computes its master's eligibility.
- Arbitration logic and address decode stay in im_arbiter.

## Test plan
- Reset, then m0_req with m0_addr = 0x3004 → m0_gnt = 1 and im_addr = 1 in the same cycle. Next cycle m0_rvalid = 1 and m0_rdata = the word at index 1.
- Both masters request continuously with rready = 1, fixed mode, STARVE_LIMIT = 4 → m1 is granted on cycles 5, 10, 15, … and m0 on all others.
- Same stimulus with IM_ARB_RR_EN defined → grants alternate m0, m1, m0, ….
- m1_addr = 0x3002 → m1_rerr = 1, m1_rdata = 0. m1_addr = 0x2FFC → m1_rerr = 1. m1_addr = 0x6FFC → m1_rerr = 0 with data from index 4095.
- m0 slot FULL and m0_rready = 0 for 3 cycles with m0_req held → m0_gnt = 0 and rdata is stable. The cycle rready goes high, a new grant reloads the slot.
- reset_n pulsed low while both slots are FULL → rvalid drops asynchronously and no stale data appears after release.

Source files
------------

// File: rtl/im_arb_pkg.sv
// im_arb_pkg: master indices, slot encodings and default base address for im_arbiter
package im_arb_pkg;
  localparam logic M_FETCH = 1'b0;
  localparam logic M_DEBUG = 1'b1;
  typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_t;
  localparam logic [31:0] IM_BASE_ADDR = 32'h0000_3000;
endpackage

// File: rtl/im_arb_resp_slot.sv
// im_arb_resp_slot: one-entry response holding register and eligibility for one master
module im_arb_resp_slot
  import im_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        gnt,
  input  logic        rready,
  input  logic [31:0] wdata,
  input  logic        werr,
  output logic        elig,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        rerr
);
  slot_t state;
  assign rvalid = state == SLOT_FULL;
  assign elig = req && (!rvalid || rready);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SLOT_EMPTY;
      rdata <= '0;
      rerr <= 1'b0;
    end else if (gnt) begin
      state <= SLOT_FULL;
      rdata <= wdata;
      rerr <= werr;
    end else if (rready) begin
      state <= SLOT_EMPTY;
    end
  end
endmodule

// File: rtl/im_arbiter.sv
// im_arbiter: two-master arbiter for the instruction-memory read port
// IM_ARB_RR_EN selects round-robin; otherwise fixed priority with a starvation override for master 1
module im_arbiter
  import im_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = IM_BASE_ADDR,
  parameter int ADDR_W = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic [31:0]       m0_addr,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  output logic              m0_rerr,
  input  logic              m0_rready,
  input  logic              m1_req,
  input  logic [31:0]       m1_addr,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic              m1_rerr,
  input  logic              m1_rready,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [31:0]       im_rdata
);
  localparam logic [32:0] RANGE = 33'd1 << (ADDR_W + 2);
  logic e0, e1, sel, any, err;
  logic [31:0] sel_addr, off, wdata;
  logic [ADDR_W-1:0] im_addr_q;
`ifdef IM_ARB_RR_EN
  logic rr_ptr;
  assign sel = e1 && (!e0 || rr_ptr == M_DEBUG);
  // rr_ptr names the master that wins the next tie
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rr_ptr <= M_FETCH;
    else if (any) rr_ptr <= !sel;
  end
`else
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve;
  assign sel = e1 && (!e0 || starve == CW'(STARVE_LIMIT));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) starve <= '0;
    else if (!m1_req || sel) starve <= '0;
    else if (e1 && starve != CW'(STARVE_LIMIT)) starve <= starve + 1'b1;
  end
`endif
  assign any = reset_n && (e0 || e1);
  assign m0_gnt = any && !sel;
  assign m1_gnt = any && sel;
  assign sel_addr = sel ? m1_addr : m0_addr;
  // Addresses below BASE_ADDR wrap to a huge offset and fail the range test
  assign off = sel_addr - BASE_ADDR;
  assign err = (|sel_addr[1:0]) || ({1'b0, off} >= RANGE);
  assign wdata = err ? '0 : im_rdata;
  assign im_addr = any ? off[ADDR_W+1:2] : im_addr_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) im_addr_q <= '0;
    else im_addr_q <= im_addr;
  end
  im_arb_resp_slot u_slot0 (
    .clk(clk), .reset_n(reset_n), .req(m0_req), .gnt(m0_gnt), .rready(m0_rready),
    .wdata(wdata), .werr(err), .elig(e0), .rvalid(m0_rvalid), .rdata(m0_rdata), .rerr(m0_rerr)
  );
  im_arb_resp_slot u_slot1 (
    .clk(clk), .reset_n(reset_n), .req(m1_req), .gnt(m1_gnt), .rready(m1_rready),
    .wdata(wdata), .werr(err), .elig(e1), .rvalid(m1_rvalid), .rdata(m1_rdata), .rerr(m1_rerr)
  );
endmodule

// File: tb/tb_im_arbiter.sv
// tb_im_arbiter: scoreboard bench for im_arbiter with a combinational memory model
module tb_im_arbiter;
  logic clk = 1'b0, reset_n = 1'b0;
  logic m0_req = 1'b0, m1_req = 1'b0, m0_rready = 1'b0, m1_rready = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0;
  logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rerr, m1_rerr;
  logic [31:0] m0_rdata, m1_rdata, im_rdata;
  logic [11:0] im_addr;
  int pass_cnt = 0, total_cnt = 0;
  logic [32:0] q0[$], q1[$];

  im_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_rerr(m0_rerr), .m0_rready(m0_rready),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_rerr(m1_rerr), .m1_rready(m1_rready),
    .im_addr(im_addr), .im_rdata(im_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [11:0] i);
    return {8'hA5, i, ~i};
  endfunction
  assign im_rdata = mem_word(im_addr);

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic push_exp(input bit m, input logic [31:0] a);
    logic [31:0] off;
    logic e;
    logic [32:0] v;
    off = a - 32'h0000_3000;
    e = (a[1:0] != 2'b00) || (off >= 32'h0000_4000);
    v = {e, e ? 32'h0 : mem_word(off[13:2])};
    if (m) q1.push_back(v);
    else q0.push_back(v);
  endtask

  task automatic drive(input logic r0, input logic [31:0] a0, input logic rr0,
                       input logic r1, input logic [31:0] a1, input logic rr1);
    m0_req = r0; m0_addr = a0; m0_rready = rr0;
    m1_req = r1; m1_addr = a1; m1_rready = rr1;
  endtask

  task automatic cycle_chk(input string name, input logic eg0, input logic eg1);
    @(negedge clk);
    chk({name, " m0_gnt"}, 33'(m0_gnt), 33'(eg0));
    chk({name, " m1_gnt"}, 33'(m1_gnt), 33'(eg1));
    if (eg0) push_exp(1'b0, m0_addr);
    if (eg1) push_exp(1'b1, m1_addr);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    q0.delete();
    q1.delete();
    reset_n = 1'b1;
  endtask

  // Monitor: every consumed response is checked against the oldest expectation
  always @(negedge clk) begin
    if (m0_rvalid && m0_rready) begin
      if (q0.size() == 0) begin
        total_cnt++;
        $display("FAIL m0 resp: got %h with no expected entry", {m0_rerr, m0_rdata});
      end else chk("m0 resp", {m0_rerr, m0_rdata}, q0.pop_front());
    end
    if (m1_rvalid && m1_rready) begin
      if (q1.size() == 0) begin
        total_cnt++;
        $display("FAIL m1 resp: got %h with no expected entry", {m1_rerr, m1_rdata});
      end else chk("m1 resp", {m1_rerr, m1_rdata}, q1.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst m0_gnt", 33'(m0_gnt), 33'd0);
    chk("rst m1_gnt", 33'(m1_gnt), 33'd0);
    chk("rst rvalid", 33'({m0_rvalid, m1_rvalid}), 33'd0);
    chk("rst m0 slot", {m0_rerr, m0_rdata}, 33'd0);
    chk("rst m1 slot", {m1_rerr, m1_rdata}, 33'd0);
    chk("rst im_addr", 33'(im_addr), 33'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    // Single fetch at word 1
    drive(1, 32'h3004, 1, 0, 0, 1);
    @(negedge clk);
    chk("single im_addr", 33'(im_addr), 33'd1);
    @(posedge clk);
    #1;
    push_exp(1'b0, 32'h3004);
    drive(0, 0, 1, 0, 0, 1);
    @(negedge clk);
    chk("single rvalid", 33'(m0_rvalid), 33'd1);
    chk("im_addr hold", 33'(im_addr), 33'd1);
    @(posedge clk);
    #1;
    // Both masters streaming
    do_reset();
    for (int c = 1; c <= 15; c++) begin
      drive(1, 32'h3000 + 32'(c * 4), 1, 1, 32'h3100 + 32'(c * 4), 1);
`ifdef IM_ARB_RR_EN
      cycle_chk("stream", c % 2 == 1, c % 2 == 0);
`else
      cycle_chk("stream", c % 5 != 0, c % 5 == 0);
`endif
    end
    drive(0, 0, 1, 0, 0, 1);
    cycle_chk("drain", 0, 0);
    // Error decode on master 1
    drive(0, 0, 1, 1, 32'h3002, 1);
    cycle_chk("misaligned", 0, 1);
    drive(0, 0, 1, 1, 32'h2FFC, 1);
    cycle_chk("below base", 0, 1);
    drive(0, 0, 1, 1, 32'h6FFC, 1);
    @(negedge clk);
    chk("top word im_addr", 33'(im_addr), 33'd4095);
    @(posedge clk);
    #1;
    push_exp(1'b1, 32'h6FFC);
    drive(0, 0, 1, 1, 32'h7000, 1);
    cycle_chk("past top", 0, 1);
    drive(0, 0, 1, 0, 0, 1);
    cycle_chk("drain", 0, 0);
    // Backpressure on master 0
    drive(1, 32'h3010, 1, 0, 0, 1);
    cycle_chk("bp load", 1, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h3020, 0, 0, 0, 1);
      cycle_chk("bp hold", 0, 0);
      chk("bp stable", {m0_rvalid, m0_rdata}, {1'b1, mem_word(12'd4)});
    end
    drive(1, 32'h3020, 1, 0, 0, 1);
    cycle_chk("bp reload", 1, 0);
    drive(0, 0, 1, 0, 0, 1);
    cycle_chk("drain", 0, 0);
    // Async reset with both slots full
    drive(1, 32'h3040, 0, 0, 0, 0);
    cycle_chk("fill m0", 1, 0);
    drive(0, 0, 0, 1, 32'h3044, 0);
    cycle_chk("fill m1", 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    chk("full before rst", 33'({m0_rvalid, m1_rvalid}), 33'd3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async rvalid", 33'({m0_rvalid, m1_rvalid}), 33'd0);
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("post rst rvalid", 33'({m0_rvalid, m1_rvalid}), 33'd0);
    chk("post rst data", {m0_rdata, m1_rdata[0]}, 33'd0);
    @(posedge clk);
    #1;
    drive(0, 0, 1, 1, 32'h3008, 1);
    cycle_chk("after rst", 0, 1);
    drive(0, 0, 1, 0, 0, 1);
    cycle_chk("drain", 0, 0);
    chk("q0 empty", 33'(q0.size()), 33'd0);
    chk("q1 empty", 33'(q1.size()), 33'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
